dw_conv_tm: RTL and testbench
=============================

// Module: dw_conv_tm
// PURPOSE
//  Time-multiplexed depthwise 3x3 convolution stage with programmable weights and bias, and ReLU6-style requantisation.
//  Processes CHANNELS channels LANES at a time; replaces the hardwired one-shot depthwise layers.
//  Sits between upstream window buffer (valid/ready) and downstream pointwise layer (valid/ready).
// PARAMETERS
//  CHANNELS  8   channels per input window; CHANNELS % LANES == 0 else elaboration $error
//  LANES     2   channels computed per cycle; NGROUPS = CHANNELS/LANES
//  KSIZE     9   taps per channel (3x3 window)
//  ACT_W     16  signed activation width (in and out)
//  WGT_W     4   signed weight width
//  BIAS_W    8   signed bias width
//  ACC_W     32  accumulator width; wraps modulo 2^ACC_W
//  SHIFT     3   requant right shift (arithmetic); must be >= 1
//  CLIP_MAX  6   saturation ceiling, in output units
// PORTS
//  clk        in   1                      clock
//  rstn       in   1                      synchronous active-low reset
//  in_valid   in   1                      input window valid
//  in_ready   out  1                      block can accept window
//  in_act     in   CHANNELS*KSIZE*ACT_W   ch c tap k at [(c*KSIZE+k)*ACT_W +: ACT_W]
//  out_valid  out  1                      result valid
//  out_ready  in   1                      downstream accepts result
//  out_act    out  CHANNELS*ACT_W         ch c at [c*ACT_W +: ACT_W]
//  wgt_we     in   1                      weight/bias write strobe
//  wgt_addr   in   $clog2(CHANNELS)       channel index to write
//  wgt_data   in   KSIZE*WGT_W+BIAS_W     {bias, tap[KSIZE-1..0]}; tap k at [k*WGT_W +: WGT_W]
//  busy       out  1                      state != IDLE
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): state IDLE, group cnt 0, input reg, out_act, all weights and biases = 0; out_valid=0, in_ready=1, busy=0.
//  Reset mid-operation aborts the window; no partial result is ever presented.
//  FSM: IDLE -> COMPUTE on in_valid&&in_ready (edge E0; in_act captured).
//       COMPUTE: at edge E0+1+g channels g*LANES..g*LANES+LANES-1 written to out_act; cnt++.
//       COMPUTE -> DONE at edge E0+NGROUPS (last group); out_valid=1 from then.
//       DONE -> IDLE on out_ready (out_valid held, out_act stable until then).
//  in_ready=1 only in IDLE; no accept in the DONE->IDLE cycle. Throughput: 1 window per NGROUPS+2 cycles min.
//  Channels with out_act not yet written this window hold the previous window's values (not visible: out_valid=0).
//  Per channel: acc = sum_k sext(w[k]*x[k]) + sext(bias), ACC_W wide signed.
//   if acc<0 -> 0; else r = acc>>>SHIFT; out = (r>CLIP_MAX) ? CLIP_MAX : r[ACT_W-1:0].
//  Weight writes: applied at the clock edge only in IDLE; ignored in COMPUTE/DONE.
//   A write in the same cycle as an accepted input is applied, and that window uses the new value.
// CONFIGURATION
//  DW_CONV_ROUND_EN defined: requant adds 2^(SHIFT-1) to non-negative acc before shift (round half up).
//  Not defined: plain truncation (floor). Clip and negative->0 are identical in both builds.
// STRUCTURE
//  Package dw_conv_pkg: state_t enum {IDLE,COMPUTE,DONE}; function requant(acc, shift, clip).
//  Sub-module dw_mac_lane: one channel, KSIZE-tap MAC + bias + requant, combinational.
//   LANES instances, fed by group mux; top holds FSM, counter, weight regfile, buffers.
// TESTING (defaults CHANNELS=8, LANES=2)
//  1 ch0 w=all 1, bias 0, ch0 taps all 8 -> acc 72, 72>>3=9 -> out ch0=6; out_valid 4 cycles after accept.
//  2 ch1 w=all 1, bias 0, taps all 4 -> acc 36 -> ch1=4 (ROUND_EN undef) / 5 (ROUND_EN def).
//  3 ch7 w=all -1, taps all 3 -> acc -27 -> ch7=0; ch2 w=0, bias 16 -> ch2=2.
//  4 out_ready=0 for 10 cycles in DONE -> out_valid/out_act stable, in_ready=0, in_valid ignored.
//  5 wgt_we to ch0 during COMPUTE -> ignored; result uses old weights; same write in IDLE takes effect.
//  6 rstn=0 at group 2 of COMPUTE -> next cycle IDLE, out_valid=0, weights 0; new window -> all outs = 0.

Source files
------------

// File: rtl/dw_conv_pkg.sv
// Shared types and requantisation helper for the depthwise conv stage.
// Optional feature macro: DW_CONV_ROUND_EN (round half up before shift).
package dw_conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    localparam int RQ_W = 64;

    // Negative -> 0, then shift right and clip to the ceiling.
    function automatic logic signed [RQ_W-1:0] requant(
        input logic signed [RQ_W-1:0] acc,
        input int                     shift,
        input int                     clip
    );
        logic signed [RQ_W-1:0] r;
        if (acc < 0) begin
            r = '0;
        end else begin
`ifdef DW_CONV_ROUND_EN
            r = (acc + (RQ_W'(1) <<< (shift - 1))) >>> shift;
`else
            r = acc >>> shift;
`endif
            if (r > RQ_W'(clip)) begin
                r = RQ_W'(clip);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dw_mac_lane.sv
// One channel: KSIZE-tap signed MAC plus bias, then requantisation.
// Purely combinational; rounding follows DW_CONV_ROUND_EN via requant().
module dw_mac_lane
    import dw_conv_pkg::*;
#(
    parameter int KSIZE    = 9,
    parameter int ACT_W    = 16,
    parameter int WGT_W    = 4,
    parameter int BIAS_W   = 8,
    parameter int ACC_W    = 32,
    parameter int SHIFT    = 3,
    parameter int CLIP_MAX = 6
) (
    input  logic [KSIZE*ACT_W-1:0] x,
    input  logic [KSIZE*WGT_W-1:0] w,
    input  logic [BIAS_W-1:0]      bias,
    output logic [ACT_W-1:0]       y
);

    localparam int PW = ACT_W + WGT_W;

    logic signed [PW-1:0]    prod [KSIZE];
    logic signed [ACC_W-1:0] acc;
    logic signed [RQ_W-1:0]  rq;
    logic                    unused_rq;

    // Sum of tap products plus bias, wrapping at ACC_W, then requant.
    always_comb begin
        acc = ACC_W'($signed(bias));
        for (int k = 0; k < KSIZE; k++) begin
            prod[k] = PW'($signed(x[k*ACT_W +: ACT_W]))
                    * PW'($signed(w[k*WGT_W +: WGT_W]));
            acc = acc + ACC_W'(prod[k]);
        end
        rq = requant(RQ_W'(acc), SHIFT, CLIP_MAX);
        y  = rq[ACT_W-1:0];
    end

    assign unused_rq = ^rq[RQ_W-1:ACT_W];

endmodule

// File: rtl/dw_conv_tm.sv
// Time-multiplexed depthwise 3x3 conv: LANES channels per cycle.
// Optional feature macro: DW_CONV_ROUND_EN (rounding in requant).
module dw_conv_tm
    import dw_conv_pkg::*;
#(
    parameter  int CHANNELS = 8,
    parameter  int LANES    = 2,
    parameter  int KSIZE    = 9,
    parameter  int ACT_W    = 16,
    parameter  int WGT_W    = 4,
    parameter  int BIAS_W   = 8,
    parameter  int ACC_W    = 32,
    parameter  int SHIFT    = 3,
    parameter  int CLIP_MAX = 6,
    localparam int NGROUPS  = CHANNELS / LANES,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int GW       = (NGROUPS > 1) ? $clog2(NGROUPS) : 1,
    localparam int WD_W     = KSIZE*WGT_W + BIAS_W
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS*KSIZE*ACT_W-1:0] in_act,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNELS*ACT_W-1:0]       out_act,
    input  logic                            wgt_we,
    input  logic [CW-1:0]                   wgt_addr,
    input  logic [WD_W-1:0]                 wgt_data,
    output logic                            busy
);

    if (CHANNELS % LANES != 0) begin : g_bad_lanes
        $error("CHANNELS must be a multiple of LANES");
    end
    if (SHIFT < 1) begin : g_bad_shift
        $error("SHIFT must be >= 1");
    end

    state_t                          state_q, state_d;
    logic [GW-1:0]                   cnt_q, cnt_d;
    logic [CHANNELS*KSIZE*ACT_W-1:0] act_q, act_d;
    logic [CHANNELS*ACT_W-1:0]       out_q, out_d;
    logic [WD_W-1:0]                 wgt_q [CHANNELS];
    logic [WD_W-1:0]                 wgt_d [CHANNELS];
    logic                            out_valid_q, out_valid_d;
    logic                            in_ready_q, in_ready_d;
    logic                            busy_q, busy_d;

    logic [KSIZE*ACT_W-1:0] lane_x [LANES];
    logic [KSIZE*WGT_W-1:0] lane_w [LANES];
    logic [BIAS_W-1:0]      lane_b [LANES];
    logic [ACT_W-1:0]       lane_y [LANES];

    // Route the current group's activations and weights to the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_x[l] = act_q[(int'(cnt_q)*LANES + l)*KSIZE*ACT_W
                              +: KSIZE*ACT_W];
            lane_w[l] = wgt_q[int'(cnt_q)*LANES + l][KSIZE*WGT_W-1:0];
            lane_b[l] = wgt_q[int'(cnt_q)*LANES + l][WD_W-1 -: BIAS_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dw_mac_lane #(
            .KSIZE    (KSIZE),
            .ACT_W    (ACT_W),
            .WGT_W    (WGT_W),
            .BIAS_W   (BIAS_W),
            .ACC_W    (ACC_W),
            .SHIFT    (SHIFT),
            .CLIP_MAX (CLIP_MAX)
        ) u_lane (
            .x    (lane_x[l]),
            .w    (lane_w[l]),
            .bias (lane_b[l]),
            .y    (lane_y[l])
        );
    end

    // Next state: accept/write in IDLE, one group per cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        out_d   = out_q;
        wgt_d   = wgt_q;
        unique case (state_q)
            IDLE: begin
                if (wgt_we) begin
                    wgt_d[wgt_addr] = wgt_data;
                end
                if (in_valid) begin
                    act_d   = in_act;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    out_d[(int'(cnt_q)*LANES + l)*ACT_W +: ACT_W] = lane_y[l];
                end
                if (int'(cnt_q) == NGROUPS - 1) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + GW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, buffers and weight regfile with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            act_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                wgt_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            for (int c = 0; c < CHANNELS; c++) begin
                wgt_q[c] <= wgt_d[c];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_act   = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dw_conv_tm.sv
// Directed bench for dw_conv_tm (default parameters).
// Expectations switch on DW_CONV_ROUND_EN where rounding matters.
module tb_dw_conv_tm;

    localparam int CH   = 8;
    localparam int K    = 9;
    localparam int AW   = 16;
    localparam int WD_W = 44;

`ifdef DW_CONV_ROUND_EN
    localparam int CH1_EXP = 5;
`else
    localparam int CH1_EXP = 4;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [CH*K*AW-1:0] in_act;
    logic              out_valid;
    logic              out_ready;
    logic [CH*AW-1:0]  out_act;
    logic              wgt_we;
    logic [2:0]        wgt_addr;
    logic [WD_W-1:0]   wgt_data;
    logic              busy;

    int nvec = 0;
    int nerr = 0;
    int exp_out [CH];

    dw_conv_tm dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .wgt_we    (wgt_we),
        .wgt_addr  (wgt_addr),
        .wgt_data  (wgt_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [WD_W-1:0] wd(input logic [3:0] w,
                                           input logic [7:0] b);
        return {b, {9{w}}};
    endfunction

    task automatic wr(input int c, input logic [3:0] w, input logic [7:0] b);
        @(negedge clk);
        wgt_we   = 1'b1;
        wgt_addr = 3'(c);
        wgt_data = wd(w, b);
        @(negedge clk);
        wgt_we   = 1'b0;
    endtask

    task automatic set_taps(input int c, input logic [15:0] v);
        for (int k = 0; k < K; k++) begin
            in_act[(c*K + k)*AW +: AW] = v;
        end
    endtask

    task automatic start_window(input bit we, input int c,
                                input logic [3:0] w);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        if (we) begin
            wgt_we   = 1'b1;
            wgt_addr = 3'(c);
            wgt_data = wd(w, 8'h00);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wgt_we   = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
    endtask

    task automatic check_outs(input string tag);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s_ch%0d", tag, c), out_act[c*AW +: AW],
                  exp_out[c]);
        end
    endtask

    task automatic finish_window();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wgt_we    = 1'b0;
        wgt_addr  = '0;
        wgt_data  = '0;
        in_act    = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_act", out_act, 0);

        // tests 1-3
        wr(0, 4'h1, 8'd0);
        wr(1, 4'h1, 8'd0);
        wr(7, 4'hF, 8'd0);
        wr(2, 4'h0, 8'd16);
        for (int c = 0; c < CH; c++) set_taps(c, 16'd100);
        set_taps(0, 16'd8);
        set_taps(1, 16'd4);
        set_taps(7, 16'd3);
        for (int c = 0; c < CH; c++) exp_out[c] = 0;
        exp_out[0] = 6;
        exp_out[1] = CH1_EXP;
        exp_out[2] = 2;
        start_window(1'b0, 0, 4'h0);
        check("busy_compute", busy, 1);
        check("ready_compute", in_ready, 0);
        wait_done(4);
        check_outs("w1");
        finish_window();

        // test 4: backpressure in DONE
        start_window(1'b0, 0, 4'h0);
        wait_done(4);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) begin
                check("hold_valid", out_valid, 1);
                check("hold_ready", in_ready, 0);
                check("hold_ch1", out_act[1*AW +: AW], CH1_EXP);
                check("hold_ch2", out_act[2*AW +: AW], 2);
            end
        end
        in_valid = 1'b0;
        finish_window();
        check("no_accept_busy", busy, 0);

        // test 5: write ignored in COMPUTE, applied with accept in IDLE
        set_taps(0, 16'd2);
        exp_out[0] = 2;
        start_window(1'b0, 0, 4'h0);
        wgt_we   = 1'b1;
        wgt_addr = 3'd0;
        wgt_data = wd(4'h3, 8'h00);
        @(negedge clk);
        wgt_we = 1'b0;
        wait_done(3);
        check_outs("w5a");
        finish_window();
        exp_out[0] = 6;
        start_window(1'b1, 0, 4'h3);
        wait_done(4);
        check_outs("w5b");
        finish_window();

        // test 6: reset mid-COMPUTE
        start_window(1'b0, 0, 4'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_out", out_act, 0);
        for (int c = 0; c < CH; c++) exp_out[c] = 0;
        start_window(1'b0, 0, 4'h0);
        wait_done(4);
        check_outs("w6");
        finish_window();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
